serial_subtract_ctrl: RTL and testbench

- Sequencer that runs one shared 1-bit subtract cell (two cascaded half-subtract stages plus borrow OR) bit-serially, LSB first, to compute an unsigned WIDTH-bit difference A−B.
- Owns operand shift registers, the borrow flop, the bit counter and a start/busy/done handshake.
- Sits between a requesting controller and the bit-level subtractor datapath, trading latency (WIDTH cycles) for a single subtract cell.

---
 rtl/serial_subtract_ctrl_if.sv | 23 ++
 rtl/serial_subtract_ctrl.sv | 115 +++++++++++
 tb/tb_serial_subtract_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_subtract_ctrl_if.sv
// Handshake and operand/result bundle between a requesting controller and the
// bit-serial subtract sequencer.
interface serial_subtract_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial unsigned subtractor: one shared 1-bit subtract cell, LSB first,
// WIDTH cycles per operation with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one result bit per cycle, WIDTH cycles
// DONE  | done pulse; diff/borrow_out freshly valid
module serial_subtract_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_subtract_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             cell_d;
  logic             cell_br;
  logic [WIDTH-1:0] res_shifted;

  // Two cascaded half-subtractors with their borrows ORed.
  always_comb begin
    cell_d  = op_a_q[0] ^ op_b_q[0] ^ br_q;
    cell_br = (~op_a_q[0] & op_b_q[0]) | (~(op_a_q[0] ^ op_b_q[0]) & br_q);
  end

  assign res_shifted = {cell_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d  = res_shifted;
        op_a_d = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_d = {1'b0, op_b_q[WIDTH-1:1]};
        br_d   = cell_br;
        if (cnt_q == LAST_CNT) begin
          // Counter is not advanced on the last bit so it never passes WIDTH-1.
          diff_d   = res_shifted;
          borrow_d = cell_br;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed bench for serial_subtract_ctrl (WIDTH=8): reset, arithmetic and
// wrap cases, ignored start, mid-run reset and back-to-back throughput.
module tb_serial_subtract_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_subtract_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_subtract_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation at the next edge and follow it to its done pulse.
  // With inject set, a second start (a=FF, b=00) is pulsed on RUN cycle 3.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_diff, input logic exp_bo, input bit inject);
    int busy_cnt;
    bit got;
    busy_cnt = 0;
    got      = 1'b0;
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (inject && busy_cnt == 3) begin
          bus.a     = 8'hFF;
          bus.b     = 8'h00;
          bus.start = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    chk({tag, " diff"}, 32'(bus.diff), 32'(exp_diff));
    chk({tag, " borrow"}, 32'(bus.borrow_out), 32'(exp_bo));
    chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, " diff_held"}, 32'(bus.diff), 32'(exp_diff));
  endtask

  initial begin
    int extra_done;
    int done_at[$];
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h33;

    // Reset held with start asserted.
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst diff", 32'(bus.diff), 32'h00);
    chk("rst borrow", 32'(bus.borrow_out), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(bus.busy), 32'd0);

    run_op("basic 05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("wrap 03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("wrap 00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op("equal A5-A5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

    // Start pulsed mid-run must be dropped, not queued.
    run_op("busy start 10-01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk("busy start no_second_done", 32'(extra_done), 32'd0);
    chk("busy start diff_kept", 32'(bus.diff), 32'h0F);

    // Reset asserted on RUN cycle 4.
    @(negedge clk);
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst diff", 32'(bus.diff), 32'h00);
    chk("midrst borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra_done++;
    end
    chk("midrst no_activity", 32'(extra_done), 32'd0);
    run_op("after rst 80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.a     = 8'h09;
    bus.b     = 8'h04;
    bus.start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        done_at.push_back(i);
        chk("b2b diff", 32'(bus.diff), 32'h05);
        chk("b2b borrow", 32'(bus.borrow_out), 32'd0);
      end
    end
    bus.start = 1'b0;
    chk("b2b pulses", 32'(done_at.size()), 32'd4);
    if (done_at.size() >= 1) chk("b2b first_latency", 32'(done_at[0]), 32'd9);
    for (int i = 1; i < done_at.size(); i++)
      chk("b2b spacing", 32'(done_at[i] - done_at[i-1]), 32'(WIDTH + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
